id_ex_stage: RTL and testbench

- ID/EX pipeline register plus EX-side operand forwarding and load-use hazard detection.
- Captures decoded operands and control from ID each cycle.
- Resolves RAW hazards by forwarding from MEM/WB; requests a one-cycle stall on load-use.
- Drives the EX-stage ALU operands (a, b, aluc) and passes write-back/memory control downstream to EX/MEM.

---
 rtl/id_ex_stage.sv | 133 +++++++++++++
 tb/tb_id_ex_stage.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side operand forwarding from MEM/WB and
// load-use hazard detection. The register holds the decoded instruction that
// is in EX. ALU operands are produced combinationally from that register and
// from the live MEM/WB results.
module id_ex_stage #(
    parameter int WIDTH = 32,
    parameter int RA    = 5
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [WIDTH-1:0] d_qa,
    input  logic [WIDTH-1:0] d_qb,
    input  logic [WIDTH-1:0] d_imm,
    input  logic [4:0]       d_sa,
    input  logic [3:0]       d_aluc,
    input  logic             d_aluimm,
    input  logic             d_shift,
    input  logic             d_wreg,
    input  logic             d_m2reg,
    input  logic             d_wmem,
    input  logic [RA-1:0]    d_rs,
    input  logic [RA-1:0]    d_rt,
    input  logic [RA-1:0]    d_rn,
    input  logic             d_use_rs,
    input  logic             d_use_rt,
    input  logic             stall,
    input  logic             flush,
    input  logic             m_wreg,
    input  logic             m_m2reg,
    input  logic [RA-1:0]    m_rn,
    input  logic [WIDTH-1:0] m_alu,
    input  logic             w_wreg,
    input  logic [RA-1:0]    w_rn,
    input  logic [WIDTH-1:0] w_data,
    output logic [WIDTH-1:0] e_a,
    output logic [WIDTH-1:0] e_b,
    output logic [3:0]       e_aluc,
    output logic [WIDTH-1:0] e_qb,
    output logic             e_wreg,
    output logic             e_m2reg,
    output logic             e_wmem,
    output logic [RA-1:0]    e_rn,
    output logic             e_valid,
    output logic             lu_stall
);

    typedef struct packed {
        logic             valid;
        logic             wreg;
        logic             m2reg;
        logic             wmem;
        logic [RA-1:0]    rn;
        logic [RA-1:0]    rs;
        logic [RA-1:0]    rt;
        logic [3:0]       aluc;
        logic [WIDTH-1:0] qa;
        logic [WIDTH-1:0] qb;
        logic [WIDTH-1:0] imm;
        logic [4:0]       sa;
        logic             aluimm;
        logic             shift;
    } ex_t;

    ex_t ex_q, ex_d;
    logic [WIDTH-1:0] fwd_rs, fwd_rt;

    // A load in MEM has no data yet, so it never forwards from the MEM port.
    // Register 0 is hardwired and is never forwarded.
    function automatic logic [WIDTH-1:0] fwd_sel(input logic [RA-1:0] src,
                                                 input logic [WIDTH-1:0] rf_val);
        if (m_wreg && !m_m2reg && (m_rn != '0) && (m_rn == src))
            return m_alu;
        else if (w_wreg && (w_rn != '0) && (w_rn == src))
            return w_data;
        else
            return rf_val;
    endfunction

    // Load in EX whose destination is read by the instruction in ID.
    always_comb begin
        lu_stall = ex_q.valid && ex_q.wreg && ex_q.m2reg && (ex_q.rn != '0) &&
                   ((d_use_rs && (d_rs == ex_q.rn)) || (d_use_rt && (d_rt == ex_q.rn)));
    end

    // Next EX contents: flush > stall > load-use bubble > capture from ID.
    always_comb begin
        ex_d = ex_q;
        if (flush) begin
            ex_d = '0;
        end else if (stall) begin
            ex_d = ex_q;
        end else if (lu_stall) begin
            ex_d = '0;
        end else begin
            ex_d.valid  = 1'b1;
            ex_d.wreg   = d_wreg;
            ex_d.m2reg  = d_m2reg;
            ex_d.wmem   = d_wmem;
            ex_d.rn     = d_rn;
            ex_d.rs     = d_rs;
            ex_d.rt     = d_rt;
            ex_d.aluc   = d_aluc;
            ex_d.qa     = d_qa;
            ex_d.qb     = d_qb;
            ex_d.imm    = d_imm;
            ex_d.sa     = d_sa;
            ex_d.aluimm = d_aluimm;
            ex_d.shift  = d_shift;
        end
    end

    // ID/EX register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!clrn) ex_q <= '0;
        else       ex_q <= ex_d;
    end

    // Operand forwarding tracks live MEM/WB even while the register is held.
    always_comb begin
        fwd_rs  = fwd_sel(ex_q.rs, ex_q.qa);
        fwd_rt  = fwd_sel(ex_q.rt, ex_q.qb);
        e_a     = ex_q.shift  ? {{(WIDTH-5){1'b0}}, ex_q.sa} : fwd_rs;
        e_b     = ex_q.aluimm ? ex_q.imm : fwd_rt;
        e_qb    = fwd_rt;
        e_aluc  = ex_q.aluc;
        e_wreg  = ex_q.wreg;
        e_m2reg = ex_q.m2reg;
        e_wmem  = ex_q.wmem;
        e_rn    = ex_q.rn;
        e_valid = ex_q.valid;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios with constant
// expectations, then a randomized run against a behavioural model.
module tb_id_ex_stage;
    localparam int WIDTH = 32;
    localparam int RA    = 5;

    logic clk = 1'b0;
    logic clrn;
    logic [WIDTH-1:0] d_qa, d_qb, d_imm;
    logic [4:0] d_sa;
    logic [3:0] d_aluc;
    logic d_aluimm, d_shift, d_wreg, d_m2reg, d_wmem;
    logic [RA-1:0] d_rs, d_rt, d_rn;
    logic d_use_rs, d_use_rt, stall, flush;
    logic m_wreg, m_m2reg;
    logic [RA-1:0] m_rn;
    logic [WIDTH-1:0] m_alu;
    logic w_wreg;
    logic [RA-1:0] w_rn;
    logic [WIDTH-1:0] w_data;
    logic [WIDTH-1:0] e_a, e_b, e_qb;
    logic [3:0] e_aluc;
    logic e_wreg, e_m2reg, e_wmem, e_valid, lu_stall;
    logic [RA-1:0] e_rn;

    int total = 0;
    int bad   = 0;

    id_ex_stage #(.WIDTH(WIDTH), .RA(RA)) dut (
        .clk(clk), .clrn(clrn),
        .d_qa(d_qa), .d_qb(d_qb), .d_imm(d_imm), .d_sa(d_sa), .d_aluc(d_aluc),
        .d_aluimm(d_aluimm), .d_shift(d_shift), .d_wreg(d_wreg), .d_m2reg(d_m2reg),
        .d_wmem(d_wmem), .d_rs(d_rs), .d_rt(d_rt), .d_rn(d_rn),
        .d_use_rs(d_use_rs), .d_use_rt(d_use_rt), .stall(stall), .flush(flush),
        .m_wreg(m_wreg), .m_m2reg(m_m2reg), .m_rn(m_rn), .m_alu(m_alu),
        .w_wreg(w_wreg), .w_rn(w_rn), .w_data(w_data),
        .e_a(e_a), .e_b(e_b), .e_aluc(e_aluc), .e_qb(e_qb),
        .e_wreg(e_wreg), .e_m2reg(e_m2reg), .e_wmem(e_wmem), .e_rn(e_rn),
        .e_valid(e_valid), .lu_stall(lu_stall)
    );

    always #5 clk = ~clk;

    // Behavioural model: the instruction currently occupying EX.
    typedef struct {
        bit valid, wreg, m2reg, wmem, aluimm, shift;
        int unsigned rn, rs, rt, aluc, sa;
        bit [31:0] qa, qb, imm;
    } instr_t;
    instr_t ex;

    function automatic bit [31:0] model_src(int unsigned src, bit [31:0] rf);
        if (src == 0) return rf;
        if (m_wreg && !m_m2reg && m_rn == src) return m_alu;
        if (w_wreg && w_rn == src) return w_data;
        return rf;
    endfunction

    function automatic bit model_lu();
        bit hit_rs, hit_rt;
        hit_rs = d_use_rs && (d_rs == ex.rn);
        hit_rt = d_use_rt && (d_rt == ex.rn);
        return ex.valid && ex.wreg && ex.m2reg && ex.rn != 0 && (hit_rs || hit_rt);
    endfunction

    // Decide what EX holds after the coming edge, based on current inputs.
    function automatic instr_t model_next();
        instr_t n, empty;
        empty = '{default: 0};
        if (!clrn) return empty;
        if (flush) return empty;
        if (stall) return ex;
        if (model_lu()) return empty;
        n.valid = 1; n.wreg = d_wreg; n.m2reg = d_m2reg; n.wmem = d_wmem;
        n.aluimm = d_aluimm; n.shift = d_shift; n.rn = d_rn; n.rs = d_rs; n.rt = d_rt;
        n.aluc = d_aluc; n.sa = d_sa; n.qa = d_qa; n.qb = d_qb; n.imm = d_imm;
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        clrn = 1; d_qa = 0; d_qb = 0; d_imm = 0; d_sa = 0; d_aluc = 0;
        d_aluimm = 0; d_shift = 0; d_wreg = 0; d_m2reg = 0; d_wmem = 0;
        d_rs = 0; d_rt = 0; d_rn = 0; d_use_rs = 0; d_use_rt = 0;
        stall = 0; flush = 0; m_wreg = 0; m_m2reg = 0; m_rn = 0; m_alu = 0;
        w_wreg = 0; w_rn = 0; w_data = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        clrn = 0; d_wreg = 1; d_qa = 32'h99; d_rn = 3;
        tick();
        total++; if (e_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h exp=0", e_valid); end
        total++; if (e_wreg !== 1'b0) begin bad++; $display("FAIL reset_wreg got=%0h exp=0", e_wreg); end
        total++; if (e_a !== 32'h0) begin bad++; $display("FAIL reset_a got=%0h exp=0", e_a); end
        total++; if (lu_stall !== 1'b0) begin bad++; $display("FAIL reset_lu got=%0h exp=0", lu_stall); end
        clear_inputs();
        d_qa = 5; d_qb = 7; d_aluc = 0;
        tick();
        total++; if (e_a !== 32'd5) begin bad++; $display("FAIL load_a got=%0h exp=5", e_a); end
        total++; if (e_b !== 32'd7) begin bad++; $display("FAIL load_b got=%0h exp=7", e_b); end
        total++; if (e_aluc !== 4'd0) begin bad++; $display("FAIL load_aluc got=%0h exp=0", e_aluc); end
        total++; if (e_valid !== 1'b1) begin bad++; $display("FAIL load_valid got=%0h exp=1", e_valid); end
    endtask

    task automatic test_forwarding();
        clear_inputs();
        d_rs = 3; d_qa = 1; d_wreg = 1; d_rn = 9;
        tick();
        m_wreg = 1; m_rn = 3; m_alu = 32'h10; w_wreg = 1; w_rn = 3; w_data = 32'h20;
        #1;
        total++; if (e_a !== 32'h10) begin bad++; $display("FAIL fwd_mem got=%0h exp=10", e_a); end
        m_wreg = 0;
        #1;
        total++; if (e_a !== 32'h20) begin bad++; $display("FAIL fwd_wb got=%0h exp=20", e_a); end
        m_wreg = 1; m_m2reg = 1;
        #1;
        total++; if (e_a !== 32'h20) begin bad++; $display("FAIL fwd_mem_load got=%0h exp=20", e_a); end
        m_m2reg = 0; w_wreg = 0;
        d_rs = 0; d_qa = 1;
        tick();
        m_wreg = 1; m_rn = 0; m_alu = 32'h10; w_wreg = 1; w_rn = 0; w_data = 32'h20;
        #1;
        total++; if (e_a !== 32'h1) begin bad++; $display("FAIL fwd_r0 got=%0h exp=1", e_a); end
    endtask

    task automatic test_load_use();
        clear_inputs();
        d_wreg = 1; d_m2reg = 1; d_rn = 4; d_rs = 1; d_use_rs = 1;
        tick();
        // ID now holds an add that reads r4
        d_m2reg = 0; d_rn = 5; d_rs = 4; d_use_rs = 1; d_qa = 32'h99;
        #1;
        total++; if (lu_stall !== 1'b1) begin bad++; $display("FAIL lu_req got=%0h exp=1", lu_stall); end
        tick();
        m_wreg = 1; m_m2reg = 1; m_rn = 4;
        #1;
        total++; if (e_valid !== 1'b0) begin bad++; $display("FAIL lu_bubble_valid got=%0h exp=0", e_valid); end
        total++; if (e_wreg !== 1'b0) begin bad++; $display("FAIL lu_bubble_wreg got=%0h exp=0", e_wreg); end
        total++; if (lu_stall !== 1'b0) begin bad++; $display("FAIL lu_drop got=%0h exp=0", lu_stall); end
        tick();
        m_wreg = 0; m_m2reg = 0; m_rn = 0; w_wreg = 1; w_rn = 4; w_data = 32'hAB;
        #1;
        total++; if (e_valid !== 1'b1) begin bad++; $display("FAIL lu_dep_valid got=%0h exp=1", e_valid); end
        total++; if (e_a !== 32'hAB) begin bad++; $display("FAIL lu_dep_a got=%0h exp=ab", e_a); end
        // a load to r0 never creates a hazard
        clear_inputs();
        d_wreg = 1; d_m2reg = 1; d_rn = 0;
        tick();
        d_m2reg = 0; d_rt = 0; d_use_rt = 1;
        #1;
        total++; if (lu_stall !== 1'b0) begin bad++; $display("FAIL lu_r0 got=%0h exp=0", lu_stall); end
    endtask

    task automatic test_shift_imm();
        clear_inputs();
        d_shift = 1; d_sa = 5; d_aluimm = 1; d_imm = 32'hFFFF_FFF0; d_rt = 2; d_qb = 32'h33; d_qa = 32'h44;
        tick();
        w_wreg = 1; w_rn = 2; w_data = 32'h77;
        #1;
        total++; if (e_a !== 32'd5) begin bad++; $display("FAIL shift_a got=%0h exp=5", e_a); end
        total++; if (e_b !== 32'hFFFF_FFF0) begin bad++; $display("FAIL imm_b got=%0h exp=fffffff0", e_b); end
        total++; if (e_qb !== 32'h77) begin bad++; $display("FAIL imm_qb got=%0h exp=77", e_qb); end
    endtask

    task automatic test_stall_flush();
        clear_inputs();
        d_qa = 32'h11; d_qb = 32'h22; d_wreg = 1; d_wmem = 1; d_rn = 7; d_rs = 8; d_aluc = 3;
        tick();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            d_qa = $urandom; d_qb = $urandom; d_rn = 1; d_aluc = 4'(i + 5); d_wmem = 0;
            tick();
            total++; if (e_a !== 32'h11 || e_b !== 32'h22 || e_rn !== 5'd7 || e_aluc !== 4'd3 || e_valid !== 1'b1)
                begin bad++; $display("FAIL stall_hold got=%0h/%0h/%0h/%0h exp=11/22/7/3", e_a, e_b, e_rn, e_aluc); end
        end
        m_wreg = 1; m_rn = 8; m_alu = 32'hC0DE;
        #1;
        total++; if (e_a !== 32'hC0DE) begin bad++; $display("FAIL stall_fwd got=%0h exp=c0de", e_a); end
        flush = 1;
        tick();
        total++; if (e_valid !== 1'b0 || e_wmem !== 1'b0 || e_rn !== 5'd0)
            begin bad++; $display("FAIL flush_stall got=%0h/%0h/%0h exp=0/0/0", e_valid, e_wmem, e_rn); end
        // reset beats a stalled valid instruction
        clear_inputs();
        d_qa = 32'h5A; d_wreg = 1;
        tick();
        stall = 1; clrn = 0;
        tick();
        total++; if (e_valid !== 1'b0 || e_a !== 32'h0) begin bad++; $display("FAIL reset_in_stall got=%0h/%0h exp=0/0", e_valid, e_a); end
    endtask

    task automatic test_store_fwd();
        clear_inputs();
        d_wmem = 1; d_aluimm = 1; d_imm = 32'h8; d_rt = 6; d_qb = 32'h1;
        tick();
        m_wreg = 1; m_rn = 6; m_alu = 32'h55;
        #1;
        total++; if (e_b !== 32'h8) begin bad++; $display("FAIL store_b got=%0h exp=8", e_b); end
        total++; if (e_qb !== 32'h55) begin bad++; $display("FAIL store_qb got=%0h exp=55", e_qb); end
        total++; if (e_wmem !== 1'b1) begin bad++; $display("FAIL store_wmem got=%0h exp=1", e_wmem); end
    endtask

    task automatic test_random();
        bit [31:0] xa, xb, xq;
        clear_inputs();
        clrn = 0;
        tick();
        ex = '{default: 0};
        for (int i = 0; i < 400; i++) begin
            clrn = ($urandom_range(0, 29) != 0);
            d_qa = $urandom; d_qb = $urandom; d_imm = $urandom; d_sa = 5'($urandom);
            d_aluc = 4'($urandom); d_aluimm = ($urandom_range(0, 3) == 0); d_shift = ($urandom_range(0, 4) == 0);
            d_wreg = $urandom_range(0, 1); d_m2reg = ($urandom_range(0, 2) == 0); d_wmem = $urandom_range(0, 1);
            d_rs = 5'($urandom_range(0, 5)); d_rt = 5'($urandom_range(0, 5)); d_rn = 5'($urandom_range(0, 5));
            d_use_rs = $urandom_range(0, 1); d_use_rt = $urandom_range(0, 1);
            stall = ($urandom_range(0, 4) == 0); flush = ($urandom_range(0, 6) == 0);
            m_wreg = $urandom_range(0, 1); m_m2reg = $urandom_range(0, 1); m_rn = 5'($urandom_range(0, 5)); m_alu = $urandom;
            w_wreg = $urandom_range(0, 1); w_rn = 5'($urandom_range(0, 5)); w_data = $urandom;
            #1;
            xa = ex.shift ? {27'b0, ex.sa[4:0]} : model_src(ex.rs, ex.qa);
            xq = model_src(ex.rt, ex.qb);
            xb = ex.aluimm ? ex.imm : xq;
            total++; if (e_a !== xa) begin bad++; $display("FAIL rnd_a cyc=%0d got=%0h exp=%0h", i, e_a, xa); end
            total++; if (e_b !== xb) begin bad++; $display("FAIL rnd_b cyc=%0d got=%0h exp=%0h", i, e_b, xb); end
            total++; if (e_qb !== xq) begin bad++; $display("FAIL rnd_qb cyc=%0d got=%0h exp=%0h", i, e_qb, xq); end
            total++; if (lu_stall !== model_lu()) begin bad++; $display("FAIL rnd_lu cyc=%0d got=%0h exp=%0h", i, lu_stall, model_lu()); end
            total++; if ({e_valid, e_wreg, e_m2reg, e_wmem, e_rn, e_aluc} !==
                         {ex.valid, ex.wreg, ex.m2reg, ex.wmem, 5'(ex.rn), 4'(ex.aluc)})
                begin bad++; $display("FAIL rnd_ctrl cyc=%0d got=%0h exp=%0h", i,
                    {e_valid, e_wreg, e_m2reg, e_wmem, e_rn, e_aluc},
                    {ex.valid, ex.wreg, ex.m2reg, ex.wmem, 5'(ex.rn), 4'(ex.aluc)}); end
            ex = model_next();
            tick();
        end
    endtask

    initial begin
        ex = '{default: 0};
        test_reset();
        test_forwarding();
        test_load_use();
        test_shift_imm();
        test_stall_flush();
        test_store_fwd();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
